// File: rtl/fakeram_1rw1r_param_sram.sv
// rtl/fakeram_1rw1r_param_sram.sv - parametrised 1RW+1R SRAM behavioural model with post-reset clear
// Optional feature macro: FAKERAM_ERR_CHK_EN adds sticky err_out[2:0] and X-corruption on bad rw0 control.
module fakeram_1rw1r_param_sram #(
    parameter int BITS              = 32,
    parameter int WORD_DEPTH        = 384,
    parameter int ADDR_WIDTH        = 9,
    parameter int MASK_GRAN         = 8,
    parameter int RD_LATENCY        = 1,
    parameter int RW_COLLISION_MODE = 0,
    parameter int CLEAR_ON_RESET    = 1,
    parameter int MASK_W            = BITS / MASK_GRAN
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,
    input  logic                  r0_ce_in,
    input  logic [ADDR_WIDTH-1:0] r0_addr_in,
    output logic [BITS-1:0]       r0_rd_out,
    output logic                  r0_rd_valid,
    input  logic                  rw0_ce_in,
    input  logic                  rw0_we_in,
    input  logic [ADDR_WIDTH-1:0] rw0_addr_in,
    input  logic [BITS-1:0]       rw0_wd_in,
    input  logic [MASK_W-1:0]     rw0_wmask_in,
    output logic [BITS-1:0]       rw0_rd_out,
    output logic                  rw0_rd_valid
`ifdef FAKERAM_ERR_CHK_EN
    ,
    output logic [2:0]            err_out
`endif
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_C   = (ADDR_WIDTH+1)'(WORD_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clear_addr_q, clear_addr_d;
    logic                    clear_we;

    logic [BITS-1:0]         mem [WORD_DEPTH];

    logic                    r0_acc, rw_acc;
    logic                    r0_inr, rw_inr;
    logic [BITS-1:0]         r0_old, rw_old, rw_merged, r0_word;
    logic                    wr_en, coll;

    logic [RD_LATENCY-1:0]   r0_v_q, rw_v_q;
    logic [BITS-1:0]         r0_d_q [RD_LATENCY];
    logic [BITS-1:0]         rw_d_q [RD_LATENCY];

`ifdef FAKERAM_ERR_CHK_EN
    logic [2:0]              err_q;
    logic                    x_err;
    logic                    oor;
    logic                    coll_any;
`endif

    // Clear FSM state register and clear address counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            clear_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            clear_addr_q <= clear_addr_d;
        end
    end

    // Clear FSM next state: walk every word once, then hand over to normal accesses
    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        case (state_q)
            ST_CLEAR: begin
                if (CLEAR_ON_RESET == 0) begin
                    state_d = ST_READY;
                end else begin
                    clear_addr_d = clear_addr_q + 1'b1;
                    if (clear_addr_q == LAST_ADDR) begin
                        state_d = ST_READY;
                    end
                end
            end
            default: state_d = ST_READY;
        endcase
    end

    // Clear FSM outputs
    always_comb begin
        init_done = (state_q == ST_READY);
        clear_we  = (state_q == ST_CLEAR) && (CLEAR_ON_RESET != 0);
    end

    // Access qualification, old-word lookup, masked merge and collision resolution
    always_comb begin
        r0_acc    = r0_ce_in & init_done;
        rw_acc    = rw0_ce_in & init_done;
        r0_inr    = ({1'b0, r0_addr_in} < DEPTH_C);
        rw_inr    = ({1'b0, rw0_addr_in} < DEPTH_C);
        r0_old    = r0_inr ? mem[r0_addr_in] : '0;
        rw_old    = rw_inr ? mem[rw0_addr_in] : '0;
        rw_merged = rw_old;
        for (int i = 0; i < MASK_W; i++) begin
            if (rw0_wmask_in[i]) begin
                rw_merged[i*MASK_GRAN +: MASK_GRAN] = rw0_wd_in[i*MASK_GRAN +: MASK_GRAN];
            end
        end
        wr_en   = rw_acc & rw0_we_in & rw_inr;
        coll    = r0_acc & wr_en & (r0_addr_in == rw0_addr_in);
        r0_word = ((RW_COLLISION_MODE == 1) && coll) ? rw_merged : r0_old;
    end

    // Array write port: clear engine during init, rw0 masked writes afterwards
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clear_addr_q] <= '0;
        end else if (wr_en) begin
            mem[rw0_addr_in] <= rw_merged;
        end
`ifdef FAKERAM_ERR_CHK_EN
        if (x_err) begin
            for (int i = 0; i < WORD_DEPTH; i++) begin
                mem[i] <= 'x;
            end
        end
`endif
    end

    // Read pipelines: stage 0 captures the looked-up word, later stages shift; data holds when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0_v_q <= '0;
            rw_v_q <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                r0_d_q[k] <= '0;
                rw_d_q[k] <= '0;
            end
        end else begin
            r0_v_q[0] <= r0_acc;
            rw_v_q[0] <= rw_acc;
            if (r0_acc) r0_d_q[0] <= r0_word;
            if (rw_acc) rw_d_q[0] <= rw_old;
            for (int k = 1; k < RD_LATENCY; k++) begin
                r0_v_q[k] <= r0_v_q[k-1];
                rw_v_q[k] <= rw_v_q[k-1];
                if (r0_v_q[k-1]) r0_d_q[k] <= r0_d_q[k-1];
                if (rw_v_q[k-1]) rw_d_q[k] <= rw_d_q[k-1];
            end
        end
    end

    assign r0_rd_out    = r0_d_q[RD_LATENCY-1];
    assign r0_rd_valid  = r0_v_q[RD_LATENCY-1];
    assign rw0_rd_out   = rw_d_q[RD_LATENCY-1];
    assign rw0_rd_valid = rw_v_q[RD_LATENCY-1];

`ifdef FAKERAM_ERR_CHK_EN
    // Error event detection for the sticky flags
    always_comb begin
        x_err    = (rw0_ce_in === 1'b1) && init_done &&
                   ($isunknown(rw0_we_in) || $isunknown(rw0_addr_in));
        oor      = (r0_acc & ~r0_inr) | (rw_acc & ~rw_inr);
        coll_any = r0_acc & rw_acc & rw0_we_in & (r0_addr_in == rw0_addr_in);
    end

    // Sticky error flags, cleared only by reset; X on rw0 control is announced once per event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_q | {x_err, oor, coll_any};
            if (x_err) begin
                $display("%m: X on rw0 control with rw0_ce_in=1, array corrupted");
            end
        end
    end

    assign err_out = err_q;
`endif

endmodule

// File: tb/tb_fakeram_1rw1r_param_sram.sv
// tb/tb_fakeram_1rw1r_param_sram.sv - self-checking bench for fakeram_1rw1r_param_sram
module tb_fakeram_1rw1r_param_sram;

    localparam int DEPTH = 384;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_ce = 1'b0;
    logic [8:0]  r0_addr = '0;
    logic        rw0_ce = 1'b0;
    logic        rw0_we = 1'b0;
    logic [8:0]  rw0_addr = '0;
    logic [31:0] rw0_wd = '0;
    logic [3:0]  rw0_wmask = '0;

    logic        a_init, a_r0v, a_rwv;
    logic [31:0] a_r0d, a_rwd;
    logic        b_init, b_r0v, b_rwv;
    logic [31:0] b_r0d, b_rwd;
`ifdef FAKERAM_ERR_CHK_EN
    logic [2:0]  a_err, b_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fakeram_1rw1r_param_sram #(.RD_LATENCY(1), .RW_COLLISION_MODE(0)) u_a (
        .clk(clk), .rst(rst), .init_done(a_init),
        .r0_ce_in(r0_ce), .r0_addr_in(r0_addr), .r0_rd_out(a_r0d), .r0_rd_valid(a_r0v),
        .rw0_ce_in(rw0_ce), .rw0_we_in(rw0_we), .rw0_addr_in(rw0_addr), .rw0_wd_in(rw0_wd),
        .rw0_wmask_in(rw0_wmask), .rw0_rd_out(a_rwd), .rw0_rd_valid(a_rwv)
`ifdef FAKERAM_ERR_CHK_EN
        , .err_out(a_err)
`endif
    );

    fakeram_1rw1r_param_sram #(.RD_LATENCY(3), .RW_COLLISION_MODE(1)) u_b (
        .clk(clk), .rst(rst), .init_done(b_init),
        .r0_ce_in(r0_ce), .r0_addr_in(r0_addr), .r0_rd_out(b_r0d), .r0_rd_valid(b_r0v),
        .rw0_ce_in(rw0_ce), .rw0_we_in(rw0_we), .rw0_addr_in(rw0_addr), .rw0_wd_in(rw0_wd),
        .rw0_wmask_in(rw0_wmask), .rw0_rd_out(b_rwd), .rw0_rd_valid(b_rwv)
`ifdef FAKERAM_ERR_CHK_EN
        , .err_out(b_err)
`endif
    );

    // Reference model state
    logic [31:0] mem_m [DEPTH];
    bit          ready_m = 1'b0;
    int          clr_cnt = 0;
    bit          hv0[$], hv1[$];
    logic [31:0] hd0a[$], hd0b[$], hd1[$];
    logic [31:0] ha0 = '0, ha1 = '0, hb0 = '0, hb1 = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = m[i] ? wd[i*8 +: 8] : old[i*8 +: 8];
        return r;
    endfunction

    // One clock: predict from current inputs, advance, then compare both instances at the negedge
    task automatic tick();
        bit acc0, acc1, wr, coll;
        logic [31:0] old0, old1, mrg;
        int n;
        acc0 = !rst && ready_m && r0_ce;
        acc1 = !rst && ready_m && rw0_ce;
        old0 = (acc0 && r0_addr < DEPTH) ? mem_m[r0_addr] : 32'h0;
        old1 = (acc1 && rw0_addr < DEPTH) ? mem_m[rw0_addr] : 32'h0;
        mrg  = merge(old1, rw0_wd, rw0_wmask);
        wr   = acc1 && rw0_we && (rw0_addr < DEPTH);
        coll = wr && acc0 && (r0_addr == rw0_addr);
        hv0.push_back(acc0);
        hv1.push_back(acc1);
        hd0a.push_back(old0);
        hd0b.push_back(coll ? mrg : old0);
        hd1.push_back(old1);
        @(posedge clk);
        if (rst) begin
            ready_m = 1'b0; clr_cnt = 0;
            ha0 = '0; ha1 = '0; hb0 = '0; hb1 = '0;
        end else begin
            if (wr) mem_m[rw0_addr] = mrg;
            if (!ready_m) begin
                clr_cnt++;
                if (clr_cnt == DEPTH) begin
                    ready_m = 1'b1;
                    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
                end
            end
        end
        @(negedge clk);
        n = hv0.size();
        if (hv0[n-1]) ha0 = hd0a[n-1];
        if (hv1[n-1]) ha1 = hd1[n-1];
        if (n >= 3) begin
            if (hv0[n-3]) hb0 = hd0b[n-3];
            if (hv1[n-3]) hb1 = hd1[n-3];
        end
        chk("a_init_done", a_init, ready_m);
        chk("b_init_done", b_init, ready_m);
        chk("a_r0_valid", a_r0v, hv0[n-1]);
        chk("a_r0_data", a_r0d, ha0);
        chk("a_rw0_valid", a_rwv, hv1[n-1]);
        chk("a_rw0_data", a_rwd, ha1);
        chk("b_r0_valid", b_r0v, (n >= 3) ? hv0[n-3] : 1'b0);
        chk("b_r0_data", b_r0d, hb0);
        chk("b_rw0_valid", b_rwv, (n >= 3) ? hv1[n-3] : 1'b0);
        chk("b_rw0_data", b_rwd, hb1);
    endtask

    task automatic drive(input bit c0, input logic [8:0] a0, input bit c1, input bit we,
                         input logic [8:0] a1, input logic [31:0] wd, input logic [3:0] m);
        r0_ce = c0; r0_addr = a0;
        rw0_ce = c1; rw0_we = we; rw0_addr = a1; rw0_wd = wd; rw0_wmask = m;
        tick();
    endtask

    task automatic idle(input int k);
        r0_ce = 1'b0; rw0_ce = 1'b0; rw0_we = 1'b0;
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic do_reset();
        r0_ce = 1'b0; rw0_ce = 1'b0; rw0_we = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset, full clear, read of a cleared word
        do_reset();
        idle(DEPTH);
        drive(1, 9'd5, 0, 0, 9'd0, 32'h0, 4'h0);
        idle(3);

        // Reset in the middle of the clear, with an access attempted during the clear
        do_reset();
        idle(50);
        drive(1, 9'd3, 1, 1, 9'd3, 32'hDEADBEEF, 4'hF);
        idle(49);
        do_reset();
        idle(DEPTH);
        drive(1, 9'd3, 1, 0, 9'd5, 32'h0, 4'h0);
        idle(3);

        // Masked write over a known word
        drive(0, 9'd0, 1, 1, 9'd10, 32'h11223344, 4'hF);
        drive(0, 9'd0, 1, 1, 9'd10, 32'hAABBCCDD, 4'b0101);
        drive(1, 9'd10, 0, 0, 9'd0, 32'h0, 4'h0);
        chk("masked_merge_const", a_r0d, 32'h11BB33DD);
        idle(3);

        // Same-address collision with a full-mask write
        drive(1, 9'd7, 1, 1, 9'd7, 32'hFFFFFFFF, 4'hF);
        chk("coll_mode0_r0", a_r0d, 32'h0);
        chk("coll_mode0_rw0", a_rwd, 32'h0);
        idle(2);
        chk("coll_mode1_r0", b_r0d, 32'hFFFFFFFF);
        chk("coll_mode1_rw0", b_rwd, 32'h0);
        idle(2);

        // Back-to-back reads through the deep pipeline
        drive(0, 9'd0, 1, 1, 9'd0, 32'h0A0A0A0A, 4'hF);
        drive(0, 9'd0, 1, 1, 9'd1, 32'h1B1B1B1B, 4'hF);
        drive(0, 9'd0, 1, 1, 9'd2, 32'h2C2C2C2C, 4'hF);
        drive(1, 9'd0, 0, 0, 9'd0, 32'h0, 4'h0);
        drive(1, 9'd1, 0, 0, 9'd0, 32'h0, 4'h0);
        drive(1, 9'd2, 0, 0, 9'd0, 32'h0, 4'h0);
        chk("lat3_first", b_r0d, 32'h0A0A0A0A);
        idle(4);

        // Random traffic, including out-of-range addresses and forced same-address pairs
        for (int i = 0; i < 400; i++) begin
            logic [8:0] ra, wa;
            ra = 9'($urandom_range(0, 399));
            wa = ($urandom_range(0, 3) == 0) ? ra : 9'($urandom_range(0, 399));
            drive(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  wa, 32'($urandom), 4'($urandom_range(0, 15)));
        end
        idle(4);

`ifdef FAKERAM_ERR_CHK_EN
        // Out-of-range access flags bit1 only; reset clears the flags
        do_reset();
        idle(DEPTH);
        drive(1, 9'd400, 0, 0, 9'd0, 32'h0, 4'h0);
        chk("oor_read_zero", a_r0d, 32'h0);
        idle(3);
        chk("a_err_oor", a_err, 3'b010);
        chk("b_err_oor", b_err, 3'b010);
        do_reset();
        chk("a_err_cleared", a_err, 3'b000);
        chk("b_err_cleared", b_err, 3'b000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fakeram_1rw1r_param_sram.md
Name: fakeram_1rw1r_param_sram

Overview:
Parametrised behavioural model of a 1RW+1R SRAM macro for RTL simulation. It generalises the fixed-geometry fakeram macros: arbitrary width, depth and mask granularity, configurable read latency, and a defined same-address collision policy. A post-reset clear engine zeroes the array. It sits in the sram/verilog collection and drop-in replaces fixed fakeram instances in the liteeth and sibling designs.

Parameters:
BITS, 32, data word width; must be a multiple of MASK_GRAN
WORD_DEPTH, 384, number of words
ADDR_WIDTH, 9, address width; must satisfy 2**ADDR_WIDTH >= WORD_DEPTH
MASK_GRAN, 8, bits per write-mask lane; MASK_W = BITS/MASK_GRAN
RD_LATENCY, 1, read latency in cycles; legal values 1..3
RW_COLLISION_MODE, 0, r0 read vs rw0 write to the same address: 0 = read-first (old data), 1 = write-through (merged new data)
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset before accepting accesses

Ports:
clk  in  1  single clock for both ports
rst  in  1  asynchronous active-high reset
init_done  out  1  array ready; accesses are ignored while this is 0
r0_ce_in  in  1  read-port enable
r0_addr_in  in  ADDR_WIDTH  read-port address
r0_rd_out  out  BITS  read-port data
r0_rd_valid  out  1  r0_rd_out is valid this cycle
rw0_ce_in  in  1  rw-port enable
rw0_we_in  in  1  write enable; qualified by rw0_ce_in
rw0_addr_in  in  ADDR_WIDTH  rw-port address
rw0_wd_in  in  BITS  write data
rw0_wmask_in  in  MASK_W  per-lane write mask; 1 = write the lane
rw0_rd_out  out  BITS  rw-port read data
rw0_rd_valid  out  1  rw0_rd_out is valid this cycle

Behaviour:
- Reset (async assert, sync release): r0/rw0_rd_out = 0, *_rd_valid = 0, all pipeline stages cleared, init_done = 0, clear FSM = CLEAR, clear_addr = 0. Array contents are not touched by reset itself.
- Clear FSM, states CLEAR -> READY.
  - CLEAR: writes 0 to mem[clear_addr] on each cycle and increments clear_addr. After writing WORD_DEPTH-1, moves to READY, so the clear takes exactly WORD_DEPTH cycles.
  - READY: init_done = 1.
  - With CLEAR_ON_RESET=0, the FSM enters READY on the first edge after rst deasserts.
  - rst asserted during CLEAR restarts the clear from address 0.
- While init_done = 0, both ce inputs are treated as 0: no writes, no reads, and valid stays 0.
- Read timing: a read with ce=1 sampled at edge N produces data and valid=1 after edge N+RD_LATENCY-1. Valid is 1 for exactly one cycle per accepted read, and back-to-back reads are fully pipelined.
- Read data holds: rd_out keeps its last valid value while valid = 0.
- rw0 read-first: a rw0 access returns the pre-write word even when we = 1.
- rw0 write: for each lane i with rw0_wmask_in[i] = 1, mem[addr][i*MASK_GRAN +: MASK_GRAN] <= rw0_wd_in lane i. Lanes with mask 0 are unchanged. we = 1 with an all-zero mask is a no-op write but still a valid read.
- Same-cycle r0 read and rw0 write to the same address:
  - RW_COLLISION_MODE=0: r0 returns the old word.
  - RW_COLLISION_MODE=1: r0 returns the merged word (masked lanes new, other lanes old).
- Out-of-range address (addr >= WORD_DEPTH): the write is dropped, and the read returns all zeros with valid = 1.
- Both ports reading the same address in the same cycle: both return identical data.

Optional Feature:
Macro FAKERAM_ERR_CHK_EN.
- Defined: adds output port err_out[2:0], sticky and cleared only by rst.
  - bit0: same-address r0/rw0 collision with a write.
  - bit1: out-of-range address on an accepted access.
  - bit2: rw0_ce_in=1 with X on rw0_we_in or rw0_addr_in. This corrupts the entire array to X and issues a $display warning naming the instance.
- Not defined: no err_out port, no X checks, no array corruption; behaviour is otherwise identical.

Test Plan:
1. CLEAR_ON_RESET=1, WORD_DEPTH=384: release rst -> init_done rises exactly 384 cycles later. A read of addr 5 then returns 0x00000000 with r0_rd_valid pulsed once.
2. Write addr 10, wd=0xAABBCCDD, mask=4'b0101, over prior 0x11223344 -> subsequent read returns 0x11BB33DD.
3. RD_LATENCY=3: reads of addrs 0,1,2 on consecutive cycles -> valid high on 3 consecutive cycles, data in order, first valid 2 cycles after the first request edge.
4. Collision at addr 7 (old 0x0, write 0xFFFFFFFF full mask, r0 read same cycle) -> mode 0: r0 = 0x00000000; mode 1: r0 = 0xFFFFFFFF. rw0_rd_out = 0x00000000 in both modes.
5. Assert rst at cycle 100 of the clear, release it -> init_done rises a full 384 cycles after the release. An access attempted during clear produces no valid and no write.
6. FAKERAM_ERR_CHK_EN with access to addr 400 -> read 0 with valid = 1, err_out = 3'b010. A later rst clears err_out to 0.
